wave_voice_sequencer: RTL and testbench

- Multi-voice wavetable read engine for the synth datapath. Each sample frame, it time-multiplexes one shared bank of four shape ROMs (sine, square, saw, triangle) across `NUM_VOICES` voices.
- Per voice, it produces a blend ("morph") between the selected shape and the next shape.
- It sits between the per-voice phase accumulators and the mixer. It delivers a registered frame of voice samples plus a one-cycle `frame_valid` strobe per sample tick.

---
 rtl/synth_pkg.sv | 27 ++
 rtl/wave_voice_sequencer_if.sv | 33 +++
 rtl/rom.sv | 22 ++
 rtl/wave_rom_bank.sv | 28 ++
 rtl/wave_voice_sequencer.sv | 141 ++++++++++++++
 tb/tb_wave_voice_sequencer.sv | 266 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: shared types for the synth datapath.
//   shape_e     - wavetable shape codes as carried on voice_sel
//   seq_state_e - wave_voice_sequencer frame FSM states
//   next_shape  - morph target shape, wrapping triangle back to sine
package synth_pkg;

    localparam int NUM_SHAPES = 4;

    typedef enum logic [1:0] {
        SHAPE_SINE   = 2'd0,
        SHAPE_SQUARE = 2'd1,
        SHAPE_SAW    = 2'd2,
        SHAPE_TRI    = 2'd3
    } shape_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    // 2-bit add wraps naturally: TRI + 1 -> SINE.
    function automatic shape_e next_shape(input shape_e s);
        return shape_e'(s + 2'd1);
    endfunction

endpackage

// File: rtl/wave_voice_sequencer_if.sv
// wave_voice_sequencer_if: voice bus between the phase accumulators, the
// wave_voice_sequencer and the mixer.
//   master (phase side / mixer): drives sample_tick, voice_addr, voice_sel,
//                                voice_morph, overrun_clr; sees voice_data,
//                                frame_valid, busy, overrun
//   slave  (sequencer):          the reverse
// Per-voice fields are packed flat, voice v at [v*W +: W].
interface wave_voice_sequencer_if #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int MORPH_W    = 8
);
    logic                          sample_tick;
    logic [NUM_VOICES*ADDR_W-1:0]  voice_addr;
    logic [NUM_VOICES*2-1:0]       voice_sel;
    logic [NUM_VOICES*MORPH_W-1:0] voice_morph;
    logic                          overrun_clr;
    logic [NUM_VOICES*DATA_W-1:0]  voice_data;
    logic                          frame_valid;
    logic                          busy;
    logic                          overrun;

    modport master (
        output sample_tick, voice_addr, voice_sel, voice_morph, overrun_clr,
        input  voice_data, frame_valid, busy, overrun
    );

    modport slave (
        input  sample_tick, voice_addr, voice_sel, voice_morph, overrun_clr,
        output voice_data, frame_valid, busy, overrun
    );
endinterface

// File: rtl/rom.sv
// rom: single-port synchronous-read ROM, one cycle read latency.
//   clk  - read clock
//   cs   - chip select; q holds while low
//   addr - read address
//   q    - registered read data
// Contents are a self-identifying ramp: word = FILL_ID * 2**ADDR_W + addr.
// INIT_FILE names the image used by the production ROM flow.
module rom #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter     INIT_FILE = "",
  parameter int FILL_ID   = 0
) (
  input  logic              clk,
  input  logic              cs,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (cs) q <= DATA_W'(FILL_ID * (2**ADDR_W)) + DATA_W'(addr);
  end
endmodule

// File: rtl/wave_rom_bank.sv
// wave_rom_bank: the four shape ROMs on one shared address, always enabled.
//   clk  - system clock
//   addr - shared read address
//   q    - registered samples, q[shape_e] for each shape
// A/B shape selection is left to the caller.
module wave_rom_bank
    import synth_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter     SINE_FILE   = "sine.mem",
    parameter     SQUARE_FILE = "square.mem",
    parameter     SAW_FILE    = "saw.mem",
    parameter     TRI_FILE    = "triangle.mem"
) (
    input  logic                                clk,
    input  logic [ADDR_W-1:0]                   addr,
    output logic [NUM_SHAPES-1:0][DATA_W-1:0]   q
);
    rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_FILE(SINE_FILE), .FILL_ID(int'(SHAPE_SINE)))
        u_sine   (.clk(clk), .cs(1'b1), .addr(addr), .q(q[SHAPE_SINE]));
    rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_FILE(SQUARE_FILE), .FILL_ID(int'(SHAPE_SQUARE)))
        u_square (.clk(clk), .cs(1'b1), .addr(addr), .q(q[SHAPE_SQUARE]));
    rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_FILE(SAW_FILE), .FILL_ID(int'(SHAPE_SAW)))
        u_saw    (.clk(clk), .cs(1'b1), .addr(addr), .q(q[SHAPE_SAW]));
    rom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_FILE(TRI_FILE), .FILL_ID(int'(SHAPE_TRI)))
        u_tri    (.clk(clk), .cs(1'b1), .addr(addr), .q(q[SHAPE_TRI]));
endmodule

// File: rtl/wave_voice_sequencer.sv
// wave_voice_sequencer: time-multiplexes one wave_rom_bank across NUM_VOICES
// voices per sample frame and blends each voice between its base shape (A)
// and the next shape (B) by its morph weight.
//   Clk   - system clock
//   Reset - asynchronous active-low reset
//   bus   - wave_voice_sequencer_if slave: sample_tick / voice_addr /
//           voice_sel / voice_morph / overrun_clr in; voice_data /
//           frame_valid / busy / overrun out
// Pipeline per voice: address (idx) -> ROM register -> blend + slot write.
module wave_voice_sequencer
    import synth_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int MORPH_W     = 8,
    parameter     SINE_FILE   = "sine.mem",
    parameter     SQUARE_FILE = "square.mem",
    parameter     SAW_FILE    = "saw.mem",
    parameter     TRI_FILE    = "triangle.mem"
) (
    input  logic                  Clk,
    input  logic                  Reset,
    wave_voice_sequencer_if.slave bus
);
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam int PROD_W = DATA_W + MORPH_W + 1;

    seq_state_e                           state;
    logic [IDX_W-1:0]                     idx;
    logic [NUM_VOICES-1:0][ADDR_W-1:0]    snap_addr;
    logic [NUM_VOICES-1:0][1:0]           snap_sel;
    logic [NUM_VOICES-1:0][MORPH_W-1:0]   snap_morph;

    // Tags travelling alongside the ROM read register.
    logic                                 rd_vld;
    logic [IDX_W-1:0]                     rd_idx;
    shape_e                               rd_sel;
    logic [MORPH_W-1:0]                   rd_morph;

    logic [NUM_VOICES-1:0][DATA_W-1:0]    vdata;
    logic                                 frame_valid_r;
    logic                                 busy_r;
    logic                                 overrun_r;

    logic [ADDR_W-1:0]                    rom_addr;
    logic [NUM_SHAPES-1:0][DATA_W-1:0]    rom_q;

    assign rom_addr = snap_addr[idx];

    wave_rom_bank #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .SINE_FILE(SINE_FILE), .SQUARE_FILE(SQUARE_FILE),
        .SAW_FILE(SAW_FILE), .TRI_FILE(TRI_FILE)
    ) u_bank (
        .clk  (Clk),
        .addr (rom_addr),
        .q    (rom_q)
    );

    // Shared blend: A + ((B - A) * morph) >>> MORPH_W. Since morph < 2**MORPH_W
    // the result stays between A and B, so truncating to DATA_W is exact.
    logic signed [DATA_W-1:0] samp_a;
    logic signed [DATA_W-1:0] samp_b;
    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] prod;
    logic [DATA_W-1:0]        blend;

    always_comb begin
        samp_a = $signed(rom_q[rd_sel]);
        samp_b = $signed(rom_q[next_shape(rd_sel)]);
        diff   = (DATA_W+1)'(samp_b) - (DATA_W+1)'(samp_a);
        prod   = PROD_W'(diff) * PROD_W'($signed({1'b0, rd_morph}));
        blend  = DATA_W'(PROD_W'(samp_a) + (prod >>> MORPH_W));
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state         <= ST_IDLE;
            idx           <= '0;
            snap_addr     <= '0;
            snap_sel      <= '0;
            snap_morph    <= '0;
            rd_vld        <= 1'b0;
            rd_idx        <= '0;
            rd_sel        <= SHAPE_SINE;
            rd_morph      <= '0;
            vdata         <= '0;
            frame_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;

            // ROM data for voice idx lands this edge; capture its tags.
            rd_vld   <= (state == ST_RUN);
            rd_idx   <= idx;
            rd_sel   <= shape_e'(snap_sel[idx]);
            rd_morph <= snap_morph[idx];

            if (rd_vld) vdata[rd_idx] <= blend;

            // A new overrun beats a simultaneous clear.
            if (bus.sample_tick && busy_r) overrun_r <= 1'b1;
            else if (bus.overrun_clr)      overrun_r <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (bus.sample_tick) begin
                        snap_addr  <= bus.voice_addr;
                        snap_sel   <= bus.voice_sel;
                        snap_morph <= bus.voice_morph;
                        idx        <= '0;
                        busy_r     <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (idx == LAST_IDX) state <= ST_DRAIN;
                    else                 idx   <= idx + IDX_W'(1);
                end
                ST_DRAIN: begin
                    // Last voice is in the blend stage now; its slot write
                    // and the frame strobe share the next edge.
                    frame_valid_r <= 1'b1;
                    busy_r        <= 1'b0;
                    idx           <= '0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.voice_data  = vdata;
    assign bus.frame_valid = frame_valid_r;
    assign bus.busy        = busy_r;
    assign bus.overrun     = overrun_r;

endmodule

// File: tb/tb_wave_voice_sequencer.sv
// tb_wave_voice_sequencer: table-driven plus hand-sequenced checks of the
// voice sequencer. ROMs run on their ramp image: word = shape*0x1000 + addr.
module tb_wave_voice_sequencer;
    localparam int NV = 4;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int MW = 8;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    wave_voice_sequencer_if #(.NUM_VOICES(NV), .ADDR_W(AW), .DATA_W(DW), .MORPH_W(MW)) bus ();

    wave_voice_sequencer #(
        .NUM_VOICES(NV), .ADDR_W(AW), .DATA_W(DW), .MORPH_W(MW),
        .SINE_FILE(""), .SQUARE_FILE(""), .SAW_FILE(""), .TRI_FILE("")
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]    sel;
        logic [AW-1:0] addr;
        logic [MW-1:0] morph;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t          vecs [8];
    logic [DW-1:0] exp_q [$];
    int            n_pass  = 0;
    int            n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Reference blend on the ramp image, in plain integer arithmetic.
    function automatic logic [DW-1:0] model(input logic [1:0] sel, input logic [AW-1:0] addr,
                                            input logic [MW-1:0] morph);
        int a;
        int b;
        logic [1:0] nsel;
        nsel = sel + 2'd1;
        a = int'(sel)  * 4096 + int'(addr);
        b = int'(nsel) * 4096 + int'(addr);
        return DW'(a + (((b - a) * int'(morph)) >>> MW));
    endfunction

    task automatic set_voice(input int v, input logic [1:0] sel, input logic [AW-1:0] addr,
                             input logic [MW-1:0] morph);
        bus.voice_sel[v*2 +: 2]     = sel;
        bus.voice_addr[v*AW +: AW]  = addr;
        bus.voice_morph[v*MW +: MW] = morph;
    endtask

    task automatic load_vec(input int base);
        for (int v = 0; v < NV; v++) begin
            set_voice(v, vecs[base+v].sel, vecs[base+v].addr, vecs[base+v].morph);
            exp_q.push_back(vecs[base+v].exp);
        end
    endtask

    task automatic load_rand();
        logic [1:0]    s;
        logic [AW-1:0] a;
        logic [MW-1:0] m;
        for (int v = 0; v < NV; v++) begin
            s = 2'($urandom_range(0, 3));
            a = AW'($urandom_range(0, 4095));
            m = MW'($urandom_range(0, 255));
            set_voice(v, s, a, m);
            exp_q.push_back(model(s, a, m));
        end
    endtask

    // Tick sampled at the next edge (edge k); returns 1 time unit after it.
    task automatic fire();
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
    endtask

    task automatic pop_compare(input string name);
        logic [DW-1:0] e;
        for (int v = 0; v < NV; v++) begin
            if (exp_q.size() == 0) begin
                check($sformatf("%s_q_empty_v%0d", name, v), 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s_v%0d", name, v), 32'(bus.voice_data[v*DW +: DW]), 32'(e));
            end
        end
    endtask

    // Wait (bounded) for frame_valid, check edges taken, then score the slots.
    task automatic wait_frame(input string name, input int exp_edges);
        int c;
        c = 0;
        while (!bus.frame_valid && c < 20) begin
            step();
            c++;
        end
        check({name, "_done"}, 32'(bus.frame_valid), 32'd1);
        check({name, "_lat"}, 32'(c), 32'(exp_edges));
        pop_compare(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int seen;
        bus.sample_tick = 1'b0;
        bus.overrun_clr = 1'b0;
        bus.voice_addr  = '0;
        bus.voice_sel   = '0;
        bus.voice_morph = '0;

        vecs[0] = '{2'd1, 12'h010, 8'h00, 16'h1010};
        vecs[1] = '{2'd0, 12'h010, 8'h80, 16'h0810};
        vecs[2] = '{2'd0, 12'h000, 8'hFF, 16'h0FF0};
        vecs[3] = '{2'd3, 12'h010, 8'h40, 16'h2410};
        vecs[4] = '{2'd2, 12'hFFF, 8'h00, 16'h2FFF};
        vecs[5] = '{2'd2, 12'h123, 8'hFF, 16'h3113};
        vecs[6] = '{2'd1, 12'h800, 8'h80, 16'h2000};
        vecs[7] = '{2'd3, 12'hFFF, 8'hFF, 16'h102F};

        // Reset state
        step(); step();
        check("rst_vdata", 32'(bus.voice_data == '0), 32'd1);
        check("rst_fv", 32'(bus.frame_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ovr", 32'(bus.overrun), 32'd0);
        Reset = 1'b1;
        step();

        // Plain select with per-edge timing
        load_vec(0);
        fire();
        check("t1_busy_k", 32'(bus.busy), 32'd1);
        step();
        check("t1_v0_k1", 32'(bus.voice_data[0 +: DW]), 32'h0);
        step();
        check("t1_v0_k2", 32'(bus.voice_data[0 +: DW]), 32'h1010);
        check("t1_fv_k2", 32'(bus.frame_valid), 32'd0);
        step();
        check("t1_fv_k3", 32'(bus.frame_valid), 32'd0);
        step();
        check("t1_fv_k4", 32'(bus.frame_valid), 32'd0);
        step();
        check("t1_fv_k5", 32'(bus.frame_valid), 32'd1);
        check("t1_busy_k5", 32'(bus.busy), 32'd0);
        pop_compare("t1");
        step();
        check("t1_fv_k6", 32'(bus.frame_valid), 32'd0);

        // Second table frame and random frames
        load_vec(4);
        fire();
        wait_frame("tab2", NV + 1);
        for (int r = 0; r < 3; r++) begin
            load_rand();
            fire();
            wait_frame($sformatf("rnd%0d", r), NV + 1);
        end

        // Overrun: tick at k+3 ignored, tick at k+6 accepted
        load_vec(0);
        fire();
        step(); step();
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        check("ovr_set", 32'(bus.overrun), 32'd1);
        wait_frame("ovr_f1", 2);
        load_rand();
        fire();
        wait_frame("ovr_f2", NV + 1);
        check("ovr_sticky", 32'(bus.overrun), 32'd1);

        // Set beats clear in the same cycle
        load_rand();
        fire();
        bus.sample_tick = 1'b1;
        bus.overrun_clr = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        bus.overrun_clr = 1'b0;
        check("ovr_set_wins", 32'(bus.overrun), 32'd1);
        wait_frame("ovr_f3", NV);
        bus.overrun_clr = 1'b1;
        step();
        bus.overrun_clr = 1'b0;
        check("ovr_clr", 32'(bus.overrun), 32'd0);

        // Tick on the frame_valid edge is still an overrun
        load_rand();
        fire();
        repeat (NV) step();
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        check("drain_fv", 32'(bus.frame_valid), 32'd1);
        check("drain_ovr", 32'(bus.overrun), 32'd1);
        pop_compare("drain");
        step();
        check("drain_ignored", 32'(bus.busy), 32'd0);
        bus.overrun_clr = 1'b1;
        step();
        bus.overrun_clr = 1'b0;

        // Snapshot: voice 3 address changes after the tick edge
        for (int v = 0; v < NV - 1; v++) begin
            set_voice(v, vecs[v+1].sel, vecs[v+1].addr, vecs[v+1].morph);
            exp_q.push_back(vecs[v+1].exp);
        end
        set_voice(3, 2'd2, 12'h100, 8'h00);
        exp_q.push_back(16'h2100);
        fire();
        set_voice(3, 2'd2, 12'h200, 8'h00);
        wait_frame("snap1", NV + 1);
        for (int v = 0; v < NV - 1; v++) exp_q.push_back(vecs[v+1].exp);
        exp_q.push_back(16'h2200);
        fire();
        wait_frame("snap2", NV + 1);

        // Reset mid-frame
        load_vec(4);
        fire();
        step(); step();
        Reset = 1'b0;
        #1;
        check("mrst_vdata", 32'(bus.voice_data == '0), 32'd1);
        check("mrst_fv", 32'(bus.frame_valid), 32'd0);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_ovr", 32'(bus.overrun), 32'd0);
        exp_q.delete();
        seen = 0;
        repeat (6) begin
            step();
            if (bus.frame_valid) seen++;
        end
        check("mrst_no_fv", 32'(seen), 32'd0);
        Reset = 1'b1;
        step();
        load_vec(4);
        fire();
        wait_frame("post_rst", NV + 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
